windowed_repetition_pool: RTL and testbench

//  Counts repeated field values over fixed windows of accepted samples, using a pool of banked

---
 rtl/rep_pool_pkg.sv | 26 ++
 rtl/rep_pool_bank.sv | 101 ++++++++++
 rtl/windowed_repetition_pool.sv | 164 ++++++++++++++++
 tb/tb_windowed_repetition_pool.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rep_pool_pkg.sv
// Shared types and width helpers for the windowed repetition pool.
// Holds the count-mode and bank-state enums plus count-width functions.
package rep_pool_pkg;

    typedef enum logic {
        MODE_DISTINCT = 1'b0,
        MODE_QUALIFY  = 1'b1
    } count_mode_e;

    typedef enum logic [1:0] {
        IDLE_CLEAN = 2'd0,
        CLEARING   = 2'd1,
        IN_USE     = 2'd2
    } bank_state_e;

    // Width of a saturating per-value repeat count.
    function automatic int cw_of(input int rep_threshold);
        return $clog2(rep_threshold + 1);
    endfunction

    // Width of a per-window rate count (0..window_size).
    function automatic int cnt_of(input int window_size);
        return $clog2(window_size + 1);
    endfunction

endpackage

// File: rtl/rep_pool_bank.sv
// One count RAM of the pool with its background clear FSM.
// Ports: sys_clk/reset; rd_en/rd_addr -> rd_data (registered read);
//   pipe_we/pipe_addr/pipe_data (count write); retire (start a clear);
//   done (bank is clean or holding the current window, i.e. not clearing).
module rep_pool_bank
    import rep_pool_pkg::*;
#(
    parameter int AW = 16,
    parameter int DW = 1
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    input  logic          pipe_we,
    input  logic [AW-1:0] pipe_addr,
    input  logic [DW-1:0] pipe_data,
    input  logic          retire,
    output logic [DW-1:0] rd_data,
    output logic          done
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];

    bank_state_e   state_q;
    bank_state_e   state_d;
    logic [AW-1:0] clr_addr_q;
    logic [AW-1:0] clr_addr_d;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q    <= CLEARING;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Clear has priority on the write port; the pipeline never
    // targets a bank that is clearing.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        we         = 1'b0;
        waddr      = pipe_addr;
        wdata      = pipe_data;
        done       = 1'b1;
        unique case (state_q)
            CLEARING: begin
                done       = 1'b0;
                we         = 1'b1;
                waddr      = clr_addr_q;
                wdata      = '0;
                clr_addr_d = clr_addr_q + 1'b1;
                if (&clr_addr_q) begin
                    state_d = IDLE_CLEAN;
                end
            end
            IDLE_CLEAN: begin
                we = pipe_we;
                if (pipe_we) begin
                    state_d = IN_USE;
                end
            end
            IN_USE: begin
                we = pipe_we;
            end
            default: begin
                state_d    = CLEARING;
                clr_addr_d = '0;
            end
        endcase
        // The retiring window's final count write still lands this
        // cycle; clearing begins on the next one.
        if (retire) begin
            state_d    = CLEARING;
            clr_addr_d = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/windowed_repetition_pool.sv
// Counts repeated field values per window of accepted samples over a
// pool of background-cleared count banks.
// Ports: sys_clk, reset (async high); valid/field/mode in, ready out;
//   rep_rate/rate_valid/found report each completed window;
//   drop_err is sticky once a sample arrives while not ready.
module windowed_repetition_pool
    import rep_pool_pkg::*;
#(
    parameter int FIELD_SIZE      = 16,
    parameter int WINDOW_SIZE     = 32,
    parameter int REP_THRESHOLD   = 1,
    parameter int POOL_SIZE       = 4,
    parameter int FOUND_THRESHOLD = 5
) (
    input  logic                               sys_clk,
    input  logic                               reset,
    input  logic                               valid,
    input  logic [FIELD_SIZE-1:0]              field,
    input  logic                               mode,
    output logic                               ready,
    output logic [$clog2(WINDOW_SIZE+1)-1:0]   rep_rate,
    output logic                               rate_valid,
    output logic                               found,
    output logic                               drop_err
);

    localparam int CW  = cw_of(REP_THRESHOLD);
    localparam int CNT = cnt_of(WINDOW_SIZE);
    localparam int PB  = $clog2(POOL_SIZE);
    localparam int WW  = $clog2(WINDOW_SIZE);

    localparam logic [CW-1:0] RT_C     = CW'(REP_THRESHOLD);
    localparam logic [WW-1:0] LAST_IDX = WW'(WINDOW_SIZE - 1);

    typedef struct packed {
        logic [FIELD_SIZE-1:0] addr;
        logic [PB-1:0]         bank;
        logic                  last;
        logic                  valid;
    } stage_t;

    typedef struct packed {
        logic [FIELD_SIZE-1:0] addr;
        logic [PB-1:0]         bank;
        logic [CW-1:0]         data;
        logic                  valid;
    } fwd_t;

    logic [PB-1:0]    bank_q;
    logic [PB-1:0]    bank_nxt;
    logic [WW-1:0]    acc_q;
    logic [CNT-1:0]   count_q;
    logic [CNT-1:0]   count_nxt;
    stage_t           r_q;
    stage_t           w_q;
    fwd_t             fwd_q;
    count_mode_e      win_mode [POOL_SIZE];

    logic [CW-1:0]         bank_rd [POOL_SIZE];
    logic [POOL_SIZE-1:0]  bank_done;

    logic             accept;
    logic             is_last;
    logic             fwd_hit;
    logic [CW-1:0]    old_val;
    logic [CW-1:0]    new_val;
    logic             qual;
    logic             inc;
    logic             retire;
    count_mode_e      w_mode;

    always_comb begin
        ready    = bank_done[bank_q];
        accept   = valid & ready;
        is_last  = (acc_q == LAST_IDX);
        bank_nxt = bank_q + 1'b1;
        // A back-to-back hit on the same entry read the RAM in the
        // same cycle the previous count was written, so its data is stale.
        fwd_hit  = fwd_q.valid
                 && (fwd_q.addr == w_q.addr)
                 && (fwd_q.bank == w_q.bank);
        old_val  = fwd_hit ? fwd_q.data : bank_rd[w_q.bank];
        new_val  = (old_val >= RT_C) ? RT_C : old_val + 1'b1;
        qual     = (new_val == RT_C);
        w_mode   = win_mode[w_q.bank];
        inc      = 1'b0;
        if (w_q.valid) begin
            if (w_mode == MODE_QUALIFY) begin
                inc = qual;
            end else begin
                inc = qual && (old_val < RT_C);
            end
        end
        retire    = w_q.valid && w_q.last;
        count_nxt = count_q + {{(CNT-1){1'b0}}, inc};
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            bank_q     <= '0;
            acc_q      <= '0;
            count_q    <= '0;
            r_q        <= '0;
            w_q        <= '0;
            fwd_q      <= '0;
            rep_rate   <= '0;
            rate_valid <= 1'b0;
            found      <= 1'b0;
            drop_err   <= 1'b0;
            for (int i = 0; i < POOL_SIZE; i++) begin
                win_mode[i] <= MODE_DISTINCT;
            end
        end else begin
            r_q <= '{
                addr:  field,
                bank:  bank_q,
                last:  is_last,
                valid: accept
            };
            w_q   <= r_q;
            fwd_q <= '{
                addr:  w_q.addr,
                bank:  w_q.bank,
                data:  new_val,
                valid: w_q.valid
            };
            drop_err   <= drop_err | (valid & ~ready);
            rate_valid <= retire;
            if (accept) begin
                acc_q <= acc_q + 1'b1;
                if (is_last) begin
                    bank_q             <= bank_nxt;
                    win_mode[bank_nxt] <= count_mode_e'(mode);
                end
            end
            if (retire) begin
                rep_rate <= count_nxt;
                found    <= (int'(count_nxt) >= FOUND_THRESHOLD);
                count_q  <= '0;
            end else begin
                count_q  <= count_nxt;
            end
        end
    end

    for (genvar b = 0; b < POOL_SIZE; b++) begin : g_bank
        rep_pool_bank #(
            .AW (FIELD_SIZE),
            .DW (CW)
        ) u_bank (
            .sys_clk   (sys_clk),
            .reset     (reset),
            .rd_en     (r_q.valid && (r_q.bank == PB'(b))),
            .rd_addr   (r_q.addr),
            .pipe_we   (w_q.valid && (w_q.bank == PB'(b))),
            .pipe_addr (w_q.addr),
            .pipe_data (new_val),
            .retire    (retire && (w_q.bank == PB'(b))),
            .rd_data   (bank_rd[b]),
            .done      (bank_done[b])
        );
    end

endmodule

// File: tb/tb_windowed_repetition_pool.sv
// Randomized bench for windowed_repetition_pool against a per-window
// occurrence-count reference; second instance exercises a small pool.
module tb_windowed_repetition_pool;

    localparam int FS  = 4;
    localparam int WS  = 8;
    localparam int PS  = 4;
    localparam int RT  = 2;
    localparam int FT  = 2;
    localparam int FS2 = 6;
    localparam int PS2 = 2;
    localparam int CNTW = $clog2(WS + 1);

    logic            sys_clk = 1'b0;
    logic            reset;
    logic            valid, mode, ready, rate_valid, found, drop_err;
    logic [FS-1:0]   field;
    logic [CNTW-1:0] rep_rate;
    logic            valid2, mode2, ready2, rate_valid2, found2, drop_err2;
    logic [FS2-1:0]  field2;
    logic [CNTW-1:0] rep_rate2;

    windowed_repetition_pool #(
        .FIELD_SIZE(FS), .WINDOW_SIZE(WS), .REP_THRESHOLD(RT),
        .POOL_SIZE(PS), .FOUND_THRESHOLD(FT)
    ) dut (
        .sys_clk(sys_clk), .reset(reset), .valid(valid), .field(field),
        .mode(mode), .ready(ready), .rep_rate(rep_rate),
        .rate_valid(rate_valid), .found(found), .drop_err(drop_err)
    );

    windowed_repetition_pool #(
        .FIELD_SIZE(FS2), .WINDOW_SIZE(WS), .REP_THRESHOLD(RT),
        .POOL_SIZE(PS2), .FOUND_THRESHOLD(FT)
    ) dut2 (
        .sys_clk(sys_clk), .reset(reset), .valid(valid2), .field(field2),
        .mode(mode2), .ready(ready2), .rep_rate(rep_rate2),
        .rate_valid(rate_valid2), .found(found2), .drop_err(drop_err2)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int rate;
        int fnd;
        int cyc;
    } ev_t;

    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    int  last_cyc = 0;
    bit  model_mode;
    int  wf [WS];
    int  seq [3*WS];
    ev_t exp_q [$];
    ev_t obs_q [$];
    ev_t obs2_q [$];

    always @(posedge sys_clk) cyc++;

    always @(negedge sys_clk) begin
        if (rate_valid)
            obs_q.push_back('{int'(rep_rate), int'(found), cyc});
        if (rate_valid2)
            obs2_q.push_back('{int'(rep_rate2), int'(found2), cyc});
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: tally each value's occurrences in the window.
    // Mode 0 counts values seen >= RT times; mode 1 counts every
    // occurrence from the RT-th onward.
    function automatic int ref_rate(input bit m);
        int hits [64];
        int r = 0;
        for (int v = 0; v < 64; v++) hits[v] = 0;
        for (int i = 0; i < WS; i++) hits[wf[i]]++;
        for (int v = 0; v < 64; v++)
            if (hits[v] >= RT) r += m ? hits[v] - RT + 1 : 1;
        return r;
    endfunction

    task automatic send_window(input bit next_mode, input bit gaps);
        int r;
        for (int i = 0; i < WS; i++) begin
            if (gaps) begin
                while ($urandom_range(3) == 0) begin
                    valid = 1'b0;
                    field = FS'($urandom);
                    mode  = 1'($urandom_range(1));
                    @(negedge sys_clk);
                end
            end
            check("ready_at_drive", int'(ready), 1);
            valid = 1'b1;
            field = FS'(wf[i]);
            mode  = (i == WS-1) ? next_mode : 1'($urandom_range(1));
            if (i == WS-1) last_cyc = cyc + 1;
            @(negedge sys_clk);
        end
        valid = 1'b0;
        r = ref_rate(model_mode);
        exp_q.push_back('{r, int'(r >= FT), last_cyc + 2});
        model_mode = next_mode;
    endtask

    task automatic check_clear_wait();
        for (int i = 1; i <= 2**FS; i++) begin
            @(negedge sys_clk);
            check("ready_clear", int'(ready), int'(i >= 2**FS));
            if (i == 2**FS - 1) begin
                check("rate_valid_pre", int'(rate_valid), 0);
                check("rep_rate_pre", int'(rep_rate), 0);
                check("found_pre", int'(found), 0);
                check("drop_err_pre", int'(drop_err), 0);
            end
        end
    endtask

    task automatic compare_events();
        ev_t o, e;
        check("rate_pulses", obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check("rep_rate", o.rate, e.rate);
            check("found", o.fnd, e.fnd);
            check("rate_latency", o.cyc, e.cyc);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int acc, stall, guard;
        ev_t o;
        reset  = 1'b1;
        valid  = 1'b0; field  = '0; mode  = 1'b0;
        valid2 = 1'b0; field2 = '0; mode2 = 1'b0;
        model_mode = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("rst_ready", int'(ready), 0);
        check("rst_rate_valid", int'(rate_valid), 0);
        check("rst_rep_rate", int'(rep_rate), 0);
        check("rst_found", int'(found), 0);
        check("rst_drop_err", int'(drop_err), 0);
        reset = 1'b0;
        check_clear_wait();

        wf = '{1, 2, 3, 1, 1, 2, 5, 6}; send_window(1'b1, 1'b0);
        wf = '{1, 2, 3, 1, 1, 2, 5, 6}; send_window(1'b0, 1'b0);
        wf = '{7, 7, 7, 7, 7, 7, 7, 7}; send_window(1'b1, 1'b0);
        wf = '{7, 7, 7, 7, 7, 7, 7, 7}; send_window(1'b0, 1'b0);
        wf = '{3, 3, 3, 3, 3, 3, 3, 3}; send_window(1'b0, 1'b0);
        wf = '{0, 1, 2, 3, 4, 5, 6, 7}; send_window(1'b0, 1'b0);
        for (int w = 0; w < 12; w++) begin
            for (int i = 0; i < WS; i++) wf[i] = $urandom_range(3);
            send_window(1'($urandom_range(1)), 1'b1);
        end
        repeat (5) @(negedge sys_clk);
        compare_events();
        check("drop_err_clean", int'(drop_err), 0);

        for (int i = 0; i < 5; i++) begin
            valid = 1'b1;
            field = FS'(9);
            mode  = 1'b1;
            @(negedge sys_clk);
        end
        valid = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge sys_clk);
        reset = 1'b0;
        check("mid_rst_no_pulse", obs_q.size(), 0);
        check_clear_wait();
        model_mode = 1'b0;
        wf = '{1, 2, 3, 1, 1, 2, 5, 6}; send_window(1'b0, 1'b0);
        repeat (5) @(negedge sys_clk);
        compare_events();

        for (int i = 0; i < 200 && !ready2; i++) @(negedge sys_clk);
        check("dut2_ready", int'(ready2), 1);
        for (int i = 0; i < 3*WS; i++) seq[i] = $urandom_range(3);
        acc = 0; stall = 0; guard = 0;
        valid2 = 1'b1;
        while (acc < 3*WS && guard < 400) begin
            field2 = FS2'(seq[acc]);
            if (ready2) acc++;
            else stall++;
            @(negedge sys_clk);
            guard++;
        end
        valid2 = 1'b0;
        check("dut2_accepts", acc, 3*WS);
        check("dut2_stall", stall, 2**FS2 - 6);
        check("dut2_drop_err", int'(drop_err2), 1);
        repeat (5) @(negedge sys_clk);
        check("dut2_pulses", obs2_q.size(), 3);
        for (int w = 0; w < 3 && obs2_q.size() > 0; w++) begin
            for (int i = 0; i < WS; i++) wf[i] = seq[w*WS + i];
            o = obs2_q.pop_front();
            check("dut2_rep_rate", o.rate, ref_rate(1'b0));
            check("dut2_found", o.fnd, int'(ref_rate(1'b0) >= FT));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
